rf_param: RTL and testbench
===========================

Name: rf_param

Overview:
- Parametrised successor of the 8-bit 4-entry register file. Used in the microprocessor datapath between the ALU result bus and the operand buses.
- Generalised in width and depth. Writes use one address-decoded write port instead of per-register clock enables.
- Adds a second read port and optional write-to-read bypass.
- The top register is a read-only input register. It samples the external switch bus through a 2-flop synchroniser and gives change and illegal-write indications.

Parameters:
- WIDTH, 8, data width of every register and bus.
- DEPTH, 4, number of registers. Must be a power of 2 and >= 2. Entry DEPTH-1 is the switch register.
- ADDR_W, 2, address width. Must equal log2(DEPTH). Elaboration check fails otherwise.
- BYPASS, 1, 1 = read ports forward same-cycle write data. 0 = read ports return the stored value only.

Ports:
- clk, input, 1, system clock, rising-edge.
- rst, input, 1, asynchronous reset, active-high.
- we, input, 1, write enable, sampled at rising clk.
- waddr, input, ADDR_W, write address.
- wdata, input, WIDTH, write data.
- raddr_a, input, ADDR_W, read port A address.
- rdata_a, output, WIDTH, read port A data, combinational.
- raddr_b, input, ADDR_W, read port B address.
- rdata_b, output, WIDTH, read port B data, combinational.
- sw_in, input, WIDTH, asynchronous switch bus.
- sw_changed, output, 1, one-cycle pulse when the switch register takes a new value.
- wr_err, output, 1, one-cycle pulse after a write attempt to the switch register.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: while rst=1, regardless of clk:
  - registers 0..DEPTH-1 = 0;
  - sync1 = sync2 = 0;
  - sw_changed = 0; wr_err = 0.
  - With rst asserted mid-write, the write is lost.
  - First capture after release happens at the first rising edge with rst=0.
- General write: at a rising edge, if we=1 and waddr < DEPTH-1, reg[waddr] <= wdata. Registers not addressed hold their value.
- Switch register write: if we=1 and waddr = DEPTH-1, reg[DEPTH-1] is not modified. wr_err = 1 for exactly the next cycle. Back-to-back illegal writes keep wr_err high on each following cycle.
- Switch path: on every edge, sync1 <= sw_in, sync2 <= sync1, reg[DEPTH-1] <= sync2.
  - A sw_in change settled before edge N appears in reg[DEPTH-1] after edge N+2, i.e. 3-edge latency.
  - The switch path does not depend on we.
- sw_changed: registered at the same edge as the capture. sw_changed <= (sync2 != reg[DEPTH-1]). It is high for one cycle per distinct captured change. It stays 0 while the value is stable.
- Read, combinational:
  - rdata_x = reg[raddr_x].
  - If BYPASS=1, we=1, raddr_x = waddr and waddr != DEPTH-1, then rdata_x = wdata.
  - Never bypass the switch register.
  - If BYPASS=0, the new value is visible the cycle after the write edge.
- Ports A and B are independent. Same address on both ports is legal and returns identical data.
- Out-of-range addresses are not possible because DEPTH = 2^ADDR_W.
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset with DEPTH=4, WIDTH=8, sw_in=8'hA5 held: assert rst mid-cycle -> all rdata=0, sw_changed=0, wr_err=0 immediately, without waiting for a clk edge.
- Release rst with sw_in=8'hA5 held -> reg3 reads 8'hA5 after the 3rd edge. sw_changed is high for exactly that one cycle, then 0.
- Write 8'h3C to reg1 with BYPASS=1, raddr_a=1 -> rdata_a=8'h3C in the same cycle as we.
- Same as above with BYPASS=0 -> rdata_a shows the old value (0) in the write cycle and 8'h3C after the edge.
- Ports A=0, B=2 after writing 8'h11 to reg0 and 8'h22 to reg2 -> rdata_a=8'h11, rdata_b=8'h22 simultaneously. Then both ports at address 2 -> both return 8'h22.
- Write 8'hFF to address 3 while sw_in=8'h00 -> reg3 stays 8'h00 and wr_err pulses for 1 cycle. Two consecutive illegal writes -> wr_err high for 2 cycles.
- Parametrised run with WIDTH=16, DEPTH=8 -> write 16'hBEEF to reg6, read back 16'hBEEF. Switch input 16'h1234 appears in reg7 after 3 edges with one sw_changed pulse. Toggling sw_in back to 0 gives a second pulse.

Source files
------------

// File: rtl/rf_param.sv
// rtl/rf_param.sv - parametrised register file: 2 read ports, 1 write port,
// top entry is a synchronised read-only switch input register.
module rf_param #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic [WIDTH-1:0]  sw_in,
  output logic              sw_changed,
  output logic              wr_err
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_W != $clog2(DEPTH)) begin : g_param_check
    $error("rf_param: DEPTH must be a power of 2 >= 2 and ADDR_W must equal log2(DEPTH)");
  end

  localparam logic [ADDR_W-1:0] SW_ADDR = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic             sw_changed_q, sw_changed_d;
  logic             wr_err_q, wr_err_d;
  logic             wr_ok;

  // The switch entry can never be written; its only source is the synchroniser.
  assign wr_ok = we && (waddr != SW_ADDR);

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[waddr] = wdata;
    end
    regs_d[SW_ADDR] = sync2_q;
    sw_changed_d    = (sync2_q != regs_q[SW_ADDR]);
    wr_err_d        = we && (waddr == SW_ADDR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      sync1_q      <= '0;
      sync2_q      <= '0;
      sw_changed_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      sync1_q      <= sw_in;
      sync2_q      <= sync1_q;
      sw_changed_q <= sw_changed_d;
      wr_err_q     <= wr_err_d;
    end
  end

  // Bypass is qualified by wr_ok, so the switch entry is never forwarded.
  always_comb begin
    rdata_a = regs_q[raddr_a];
    if (BYPASS != 0 && wr_ok && raddr_a == waddr) begin
      rdata_a = wdata;
    end
  end

  always_comb begin
    rdata_b = regs_q[raddr_b];
    if (BYPASS != 0 && wr_ok && raddr_b == waddr) begin
      rdata_b = wdata;
    end
  end

  assign sw_changed = sw_changed_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_rf_param.sv
// tb/tb_rf_param.sv - scoreboard bench for rf_param: bypass, no-bypass and
// 16x8 instances on a shared clock and reset.
module tb_rf_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [1:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata, sw_in;

  logic [7:0] a_rdata_a, a_rdata_b, n_rdata_a, n_rdata_b;
  logic       a_sw_changed, a_wr_err, n_sw_changed, n_wr_err;

  logic        w_we;
  logic [2:0]  w_waddr, w_raddr_a, w_raddr_b;
  logic [15:0] w_wdata, w_sw_in, w_rdata_a, w_rdata_b;
  logic        w_sw_changed, w_wr_err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          sel;
    string       tag;
    logic [15:0] val;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  rf_param #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(a_rdata_a), .raddr_b(raddr_b), .rdata_b(a_rdata_b),
    .sw_in(sw_in), .sw_changed(a_sw_changed), .wr_err(a_wr_err)
  );

  rf_param #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(n_rdata_a), .raddr_b(raddr_b), .rdata_b(n_rdata_b),
    .sw_in(sw_in), .sw_changed(n_sw_changed), .wr_err(n_wr_err)
  );

  rf_param #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .BYPASS(1)) u_dut_w (
    .clk(clk), .rst(rst), .we(w_we), .waddr(w_waddr), .wdata(w_wdata),
    .raddr_a(w_raddr_a), .rdata_a(w_rdata_a), .raddr_b(w_raddr_b), .rdata_b(w_rdata_b),
    .sw_in(w_sw_in), .sw_changed(w_sw_changed), .wr_err(w_wr_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      0:  return {8'h00, a_rdata_a};
      1:  return {8'h00, a_rdata_b};
      2:  return {15'd0, a_sw_changed};
      3:  return {15'd0, a_wr_err};
      4:  return {8'h00, n_rdata_a};
      5:  return {8'h00, n_rdata_b};
      6:  return {15'd0, n_sw_changed};
      7:  return {15'd0, n_wr_err};
      8:  return w_rdata_a;
      9:  return w_rdata_b;
      10: return {15'd0, w_sw_changed};
      default: return {15'd0, w_wr_err};
    endcase
  endfunction

  task automatic push(input int sel, input string tag, input logic [15:0] val);
    sb_t e;
    e.sel = sel;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = 2'd0; wdata = 8'h00;
    raddr_a = 2'd1; raddr_b = 2'd3; sw_in = 8'hA5;
    w_we = 1'b0; w_waddr = 3'd0; w_wdata = 16'h0; w_raddr_a = 3'd6; w_raddr_b = 3'd7;
    w_sw_in = 16'h0000;

    push(0, "por_rdata_a", 16'h0); push(1, "por_rdata_b", 16'h0);
    push(2, "por_sw_changed", 16'h0); push(3, "por_wr_err", 16'h0);
    drain();

    @(negedge clk);
    rst = 1'b0;
    we = 1'b1; waddr = 2'd1; wdata = 8'h77;
    tick();
    we = 1'b0;
    tick();
    we = 1'b1; waddr = 2'd3; wdata = 8'hFF;
    tick();
    push(0, "pre_rst_reg1", 16'h0077); push(1, "pre_rst_reg3", 16'h00A5);
    push(2, "pre_rst_sw_changed", 16'h1); push(3, "pre_rst_wr_err", 16'h1);
    drain();

    // Reset lands mid-cycle with a write to reg0 pending; it must clear at once.
    #1;
    rst = 1'b1; waddr = 2'd0; wdata = 8'h99;
    push(0, "rst_rdata_a", 16'h0); push(1, "rst_rdata_b", 16'h0);
    push(2, "rst_sw_changed", 16'h0); push(3, "rst_wr_err", 16'h0);
    push(5, "rst_nb_rdata_b", 16'h0); push(9, "rst_w_rdata_b", 16'h0);
    drain();
    tick();
    @(negedge clk);
    rst = 1'b0; we = 1'b0; raddr_a = 2'd0;

    for (int i = 1; i <= 4; i++) begin
      tick();
      push(1, $sformatf("sync_reg3_e%0d", i), (i >= 3) ? 16'h00A5 : 16'h0000);
      push(2, $sformatf("sync_sw_changed_e%0d", i), (i == 3) ? 16'h1 : 16'h0);
      if (i == 1) begin
        push(0, "lost_write_reg0", 16'h0);
        push(3, "post_rst_wr_err", 16'h0);
      end
      drain();
    end

    sw_in = 8'h00;
    we = 1'b1; waddr = 2'd1; wdata = 8'h3C; raddr_a = 2'd1;
    push(0, "bypass_same_cycle", 16'h003C); push(4, "nobypass_old", 16'h0000);
    drain();
    tick();
    we = 1'b0;
    push(0, "bypass_after", 16'h003C); push(4, "nobypass_after", 16'h003C);
    drain();

    we = 1'b1; waddr = 2'd0; wdata = 8'h11;
    tick();
    waddr = 2'd2; wdata = 8'h22;
    tick();
    we = 1'b0; raddr_a = 2'd0; raddr_b = 2'd2;
    push(0, "dual_a_reg0", 16'h0011); push(1, "dual_b_reg2", 16'h0022);
    push(4, "nb_dual_a_reg0", 16'h0011); push(5, "nb_dual_b_reg2", 16'h0022);
    drain();
    raddr_a = 2'd2;
    push(0, "same_addr_a", 16'h0022); push(1, "same_addr_b", 16'h0022);
    drain();

    raddr_b = 2'd3;
    tick();
    tick();
    push(1, "sw_zero_reg3", 16'h0000);
    drain();

    we = 1'b1; waddr = 2'd3; wdata = 8'hFF;
    push(1, "no_bypass_sw_reg", 16'h0000);
    drain();
    tick();
    we = 1'b0;
    push(3, "illegal_wr_err", 16'h1); push(1, "illegal_reg3_kept", 16'h0000);
    push(7, "nb_illegal_wr_err", 16'h1);
    drain();
    tick();
    push(3, "illegal_wr_err_drop", 16'h0);
    drain();

    we = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 2) we = 1'b0;
      push(3, $sformatf("b2b_wr_err_e%0d", i), (i <= 2) ? 16'h1 : 16'h0);
      drain();
    end

    w_we = 1'b1; w_waddr = 3'd6; w_wdata = 16'hBEEF;
    push(8, "w_bypass_reg6", 16'hBEEF);
    drain();
    tick();
    w_we = 1'b0;
    push(8, "w_read_reg6", 16'hBEEF); push(11, "w_wr_err", 16'h0);
    drain();

    for (int p = 0; p < 2; p++) begin
      w_sw_in = (p == 0) ? 16'h1234 : 16'h0000;
      for (int i = 1; i <= 4; i++) begin
        tick();
        push(9, $sformatf("w_reg7_p%0d_e%0d", p, i),
             (i >= 3) ? w_sw_in : ((p == 0) ? 16'h0000 : 16'h1234));
        push(10, $sformatf("w_sw_changed_p%0d_e%0d", p, i), (i == 3) ? 16'h1 : 16'h0);
        drain();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
